// File: rtl/mult_pkg.sv
// Shared widths and state encoding for the
// multiplier / product accumulator datapath.
package mult_pkg;

    localparam int PROD_W_DEF = 64;
    localparam int CNT_W_DEF  = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ACCUM = 2'd1;
    localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/product_accumulator_if.sv
// Control, product-in and result-out handshakes
// of the product accumulator.
interface product_accumulator_if #(
    parameter int PROD_W = mult_pkg::PROD_W_DEF,
    parameter int CNT_W  = mult_pkg::CNT_W_DEF
);

    logic              start;
    logic [CNT_W-1:0]  len;
    logic              p_valid;
    logic [PROD_W-1:0] p_data;
    logic              p_ready;
    logic              acc_valid;
    logic              acc_ready;
    logic [PROD_W-1:0] acc_data;
    logic              acc_sat;
    logic              busy;

    modport master (
        output start,
        output len,
        output p_valid,
        output p_data,
        output acc_ready,
        input  p_ready,
        input  acc_valid,
        input  acc_data,
        input  acc_sat,
        input  busy
    );

    modport slave (
        input  start,
        input  len,
        input  p_valid,
        input  p_data,
        input  acc_ready,
        output p_ready,
        output acc_valid,
        output acc_data,
        output acc_sat,
        output busy
    );

endinterface

// File: rtl/sat_add.sv
// Signed saturating adder: one-bit-wider sum,
// clamped to the W-bit range on overflow.
module sat_add #(
    parameter int W = 64
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);

    logic signed [W:0] wide;
    logic [W-1:0]      max_v;
    logic [W-1:0]      min_v;

    assign wide  = {a[W-1], a} + {b[W-1], b};
    assign max_v = {1'b0, {(W-1){1'b1}}};
    assign min_v = {1'b1, {(W-1){1'b0}}};

    // Top two bits disagree only when the result left the W-bit range.
    assign ovf = wide[W] ^ wide[W-1];

    always_comb begin
        sum = wide[W-1:0];
        if (ovf) begin
            sum = wide[W] ? min_v : max_v;
        end
    end

endmodule

// File: rtl/product_accumulator.sv
// Accumulates len signed products with saturation
// and hands the sum downstream over a valid/ready port.
module product_accumulator
    import mult_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    product_accumulator_if.slave  bus
);

    state_t             state;
    logic [PROD_W-1:0]  acc;
    logic [CNT_W-1:0]   remaining;
    logic               sat;

    logic [PROD_W-1:0]  sum;
    logic               ovf;
    logic               take;

    sat_add #(
        .W (PROD_W)
    ) u_sat_add (
        .a   (acc),
        .b   (bus.p_data),
        .sum (sum),
        .ovf (ovf)
    );

    assign take = (state == ACCUM) && bus.p_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            sat       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc <= '0;
                        sat <= 1'b0;
                        if (bus.len != '0) begin
                            remaining <= bus.len;
                            state     <= ACCUM;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                ACCUM: begin
                    if (take) begin
                        acc       <= sum;
                        sat       <= sat | ovf;
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.acc_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.p_ready   = (state == ACCUM);
    assign bus.acc_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.acc_data  = acc;
    assign bus.acc_sat   = sat;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed vector bench for product_accumulator.
module tb_product_accumulator;

    localparam int PW = 64;
    localparam int CW = 8;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_bad;

    product_accumulator_if #(
        .PROD_W (PW),
        .CNT_W  (CW)
    ) bus ();

    product_accumulator #(
        .PROD_W (PW),
        .CNT_W  (CW)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0]         len;
        logic [3:0][PW-1:0]    prod;
        logic [PW-1:0]         exp_data;
        logic                  exp_sat;
    } vec_t;

    localparam logic [PW-1:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [PW-1:0] MINV = 64'h8000_0000_0000_0000;

    vec_t vecs [8];

    function automatic vec_t mk(
        input int          l,
        input logic [PW-1:0] p0,
        input logic [PW-1:0] p1,
        input logic [PW-1:0] p2,
        input logic [PW-1:0] p3,
        input logic [PW-1:0] e,
        input logic          s
    );
        vec_t v;
        v.len      = CW'(l);
        v.prod[0]  = p0;
        v.prod[1]  = p1;
        v.prod[2]  = p2;
        v.prod[3]  = p3;
        v.exp_data = e;
        v.exp_sat  = s;
        return v;
    endfunction

    task automatic chk(
        input string         name,
        input logic [PW-1:0] act,
        input logic [PW-1:0] exp
    );
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int l);
        bus.start = 1'b1;
        bus.len   = CW'(l);
        tick();
        bus.start = 1'b0;
        bus.len   = '0;
    endtask

    task automatic release_result(input string name);
        bus.acc_ready = 1'b1;
        tick();
        bus.acc_ready = 1'b0;
        chk({name, " idle valid"}, 64'(bus.acc_valid), 64'd0);
        chk({name, " idle busy"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        pulse_start(int'(v.len));
        for (int i = 0; i < int'(v.len); i++) begin
            chk({name, " p_ready"}, 64'(bus.p_ready), 64'd1);
            chk({name, " early valid"}, 64'(bus.acc_valid), 64'd0);
            bus.p_valid = 1'b1;
            bus.p_data  = v.prod[i];
            tick();
        end
        bus.p_valid = 1'b0;
        bus.p_data  = '0;
        chk({name, " acc_valid"}, 64'(bus.acc_valid), 64'd1);
        chk({name, " p_ready off"}, 64'(bus.p_ready), 64'd0);
        chk({name, " acc_data"}, bus.acc_data, v.exp_data);
        chk({name, " acc_sat"}, 64'(bus.acc_sat), 64'(v.exp_sat));
        release_result(name);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " p_ready"}, 64'(bus.p_ready), 64'd0);
        chk({name, " acc_valid"}, 64'(bus.acc_valid), 64'd0);
        chk({name, " busy"}, 64'(bus.busy), 64'd0);
        chk({name, " acc_data"}, bus.acc_data, 64'd0);
        chk({name, " acc_sat"}, 64'(bus.acc_sat), 64'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.p_valid   = 1'b0;
        bus.p_data    = '0;
        bus.acc_ready = 1'b0;
        rst_n         = 1'b0;

        vecs[0] = mk(4, -64'sd465, 64'sd377, 64'sd4455,
                     -64'sd600, 64'sd3767, 1'b0);
        vecs[1] = mk(2, MAXV, 64'd1, 0, 0, MAXV, 1'b1);
        vecs[2] = mk(2, MINV, -64'sd1, 0, 0, MINV, 1'b1);
        vecs[3] = mk(0, 0, 0, 0, 0, 64'd0, 1'b0);
        vecs[4] = mk(3, 64'sd100, -64'sd50, -64'sd25, 0,
                     64'sd25, 1'b0);
        vecs[5] = mk(1, -64'sd7, 0, 0, 0, -64'sd7, 1'b0);
        vecs[6] = mk(3, MAXV, 64'd1, -64'sd1, 0,
                     MAXV - 64'd1, 1'b1);
        vecs[7] = mk(2, MAXV - 64'd1, 64'd1, 0, 0,
                     MAXV, 1'b0);

        #1;
        chk_all_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();
        chk_all_zero("post reset");

        for (int k = 0; k < 8; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
        end

        // Gapped products, then held-off result.
        pulse_start(3);
        for (int i = 1; i <= 3; i++) begin
            bus.p_valid = 1'b0;
            tick();
            chk("gap valid", 64'(bus.acc_valid), 64'd0);
            chk("gap p_ready", 64'(bus.p_ready), 64'd1);
            bus.p_valid = 1'b1;
            bus.p_data  = 64'(i);
            tick();
        end
        bus.p_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("hold valid", 64'(bus.acc_valid), 64'd1);
            chk("hold data", bus.acc_data, 64'd6);
            chk("hold sat", 64'(bus.acc_sat), 64'd0);
            tick();
        end
        release_result("gapped");

        // Start during ACCUM and DONE must be ignored.
        pulse_start(3);
        bus.p_valid = 1'b1;
        bus.p_data  = 64'd10;
        tick();
        bus.start = 1'b1;
        bus.len   = CW'(1);
        bus.p_data = 64'd20;
        tick();
        bus.start = 1'b0;
        chk("ign mid valid", 64'(bus.acc_valid), 64'd0);
        chk("ign mid data", bus.acc_data, 64'd30);
        bus.p_data = 64'd30;
        tick();
        bus.p_valid = 1'b0;
        chk("ign valid", 64'(bus.acc_valid), 64'd1);
        chk("ign data", bus.acc_data, 64'd60);
        bus.start = 1'b1;
        bus.len   = CW'(5);
        tick();
        bus.start = 1'b0;
        chk("ign done valid", 64'(bus.acc_valid), 64'd1);
        chk("ign done data", bus.acc_data, 64'd60);
        release_result("ignore");

        // Reset in the middle of a run.
        pulse_start(4);
        bus.p_valid = 1'b1;
        bus.p_data  = 64'd5;
        tick();
        bus.p_data  = 64'd6;
        tick();
        chk("pre rst data", bus.acc_data, 64'd11);
        chk("pre rst busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        bus.p_valid = 1'b0;
        #1;
        chk_all_zero("mid reset");
        tick();
        chk_all_zero("held reset");
        rst_n = 1'b1;
        tick();
        chk("after rst valid", 64'(bus.acc_valid), 64'd0);
        run_vec(mk(1, 64'd122, 0, 0, 0, 64'd122, 1'b0),
                "post rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter PROD_W, default 64, sets the signed product and accumulator width.
REQ-002 Parameter CNT_W, default 8, sets the width of the product-count field.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is the asynchronous, active-low reset.
REQ-005 Port start  input  1  is a single-cycle pulse that begins a new accumulation.
REQ-006 Port len  input  CNT_W  is the number of products to accumulate, sampled on start.
REQ-007 Port p_valid  input  1  means an upstream product is present.
REQ-008 Port p_data  input  PROD_W  is the signed product from the upstream sequential multiplier.
REQ-009 Port p_ready  output  1  means the block accepts a product this cycle.
REQ-010 Port acc_valid  output  1  means the accumulated result is available.
REQ-011 Port acc_ready  input  1  means the downstream consumer takes the result.
REQ-012 Port acc_data  output  PROD_W  is the signed accumulated result.
REQ-013 Port acc_sat  output  1  is a sticky flag showing that saturation occurred during this accumulation.
REQ-014 Port busy  output  1  is high whenever the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-016 In IDLE, start with len!=0 SHALL clear the accumulator and acc_sat, load remaining<=len and go to ACCUM.
REQ-017 In IDLE, start with len==0 SHALL clear the accumulator and acc_sat and go directly to DONE, giving acc_data=0.
REQ-018 start SHALL be ignored in ACCUM and DONE.
REQ-019 p_ready SHALL be 1 only in ACCUM; a product is accepted only when p_valid and p_ready are both high.
REQ-020 Each accepted product SHALL update the accumulator as acc <= sat(acc + p_data), using a PROD_W+1-bit signed sum.
REQ-021 Positive overflow SHALL clamp to 2^(PROD_W-1)-1, negative overflow SHALL clamp to -2^(PROD_W-1), and either case SHALL set acc_sat.
REQ-022 acc_sat SHALL remain set until the next accepted start or reset.
REQ-023 Each accepted product SHALL decrement remaining; accepting a product when remaining==1 SHALL transition to DONE.
REQ-024 acc_valid SHALL be 1 exactly in DONE, so it asserts the cycle after the last product is accepted (latency 1).
REQ-025 acc_data and acc_sat SHALL stay stable while acc_valid=1 and acc_ready=0.
REQ-026 DONE with acc_ready=1 SHALL return to IDLE in the next cycle.
REQ-027 acc_data SHALL reflect the running accumulator in every state.

Reset
REQ-028 Asserting rst low SHALL immediately force the following: state=IDLE, accumulator=0, remaining=0, acc_sat=0, p_ready=0, acc_valid=0, busy=0.
REQ-029 A reset during ACCUM or DONE SHALL discard the partial result; no acc_valid is produced for it.
REQ-030 Reset deassertion SHALL be synchronised externally; the block needs no start until the first rising edge after release.

Structure
REQ-031 Package mult_pkg SHALL hold PROD_W, CNT_W defaults and the state enumeration (IDLE, ACCUM, DONE), shared with the multiplier stage.
REQ-032 The saturating adder SHALL be a separate combinational sub-module, sat_add, with ports a, b, sum and ovf.
REQ-033 All registers SHALL sit in a single clocked process with the asynchronous active-low reset.

Verification
REQ-034 Basic accumulation: start with len=4, then products -465, 377, 4455, -600 (one per cycle, p_valid held) -> acc_valid one cycle after the 4th product, acc_data=3767, acc_sat=0.
REQ-035 Positive saturation: len=2, products 0x7FFF_FFFF_FFFF_FFFF and 1 -> acc_data=0x7FFF_FFFF_FFFF_FFFF, acc_sat=1.
REQ-036 Negative saturation: len=2, products -2^63 and -1 -> acc_data=0x8000_0000_0000_0000, acc_sat=1.
REQ-037 Backpressure on both sides:
- p_valid gapped, len=3, products 1, 2, 3 -> acc_data=6.
- acc_ready held low 3 cycles -> acc_valid and acc_data remain constant, then IDLE one cycle after acc_ready=1.
REQ-038 Zero length and ignored start: len=0 start -> acc_valid the next cycle with acc_data=0; a start pulse issued during ACCUM is ignored, so remaining and the final sum are unchanged.
REQ-039 Reset mid-operation: rst low after 2 of 4 products -> all outputs 0 immediately; a subsequent len=1 run with product 122 -> acc_data=122.
